// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, bridge FSM states, and the
// command/response records also used by the slave-side cosim code.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Records are sized for the widest supported bus; narrower buses use the low bits.
    localparam int AXIL_MAX_ADDR_W = 32;
    localparam int AXIL_MAX_DATA_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_WAIT_B = 3'd2,
        ST_READ   = 3'd3,
        ST_WAIT_R = 3'd4,
        ST_RESP   = 3'd5
    } axil_state_e;

    typedef struct packed {
        logic                         we;
        logic [AXIL_MAX_ADDR_W-1:0]   addr;
        logic [AXIL_MAX_DATA_W-1:0]   data;
        logic [AXIL_MAX_DATA_W/8-1:0] wstrb;
    } axil_cmd_t;

    typedef struct packed {
        logic                       we;
        logic [AXIL_MAX_DATA_W-1:0] data;
        logic [1:0]                 code;
    } axil_resp_t;

endpackage

// File: rtl/axil_master_bridge.sv
// AXI4-Lite initiator: one command in, one AXI-Lite transaction out, one response back.
// Handshakes: a beat transfers on a rising edge where valid & ready are both high; valid never drops before that.
module axil_master_bridge
    import axil_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 10
) (
    input  logic                            aclk,
    input  logic                            areset,

    input  logic                            cmd_v_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_we_i,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_data_i,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb_i,

    output logic                            resp_v_o,
    input  logic                            resp_ready_i,
    output logic                            resp_we_o,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   resp_data_o,
    output logic [1:0]                      resp_code_o,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]                      m00_axi_awprot,
    output logic                            m00_axi_awvalid,
    input  logic                            m00_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                            m00_axi_wvalid,
    input  logic                            m00_axi_wready,
    input  logic [1:0]                      m00_axi_bresp,
    input  logic                            m00_axi_bvalid,
    output logic                            m00_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]                      m00_axi_arprot,
    output logic                            m00_axi_arvalid,
    input  logic                            m00_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]                      m00_axi_rresp,
    input  logic                            m00_axi_rvalid,
    output logic                            m00_axi_rready,

    output logic [2:0]                      dbg_state
);

    axil_state_e                     state;
    logic                            aw_done;
    logic                            w_done;
    logic                            we_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   data_q;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;

    logic aw_hs;
    logic w_hs;

    assign aw_hs = m00_axi_awvalid & m00_axi_awready;
    assign w_hs  = m00_axi_wvalid & m00_axi_wready;

    // Payload comes straight from the command registers, so it cannot move while a valid is up.
    assign m00_axi_awaddr = addr_q;
    assign m00_axi_araddr = addr_q;
    assign m00_axi_wdata  = data_q;
    assign m00_axi_wstrb  = wstrb_q;
    assign m00_axi_awprot = 3'b000;
    assign m00_axi_arprot = 3'b000;
    assign dbg_state      = state;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state           <= ST_IDLE;
            cmd_ready_o     <= 1'b1;
            resp_v_o        <= 1'b0;
            resp_we_o       <= 1'b0;
            resp_data_o     <= '0;
            resp_code_o     <= RESP_OKAY;
            m00_axi_awvalid <= 1'b0;
            m00_axi_wvalid  <= 1'b0;
            m00_axi_bready  <= 1'b0;
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b0;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            data_q          <= '0;
            wstrb_q         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_v_i) begin
                        addr_q      <= cmd_addr_i;
                        data_q      <= cmd_data_i;
                        wstrb_q     <= cmd_wstrb_i;
                        we_q        <= cmd_we_i;
                        cmd_ready_o <= 1'b0;
                        if (cmd_we_i) begin
                            m00_axi_awvalid <= 1'b1;
                            m00_axi_wvalid  <= 1'b1;
                            state           <= ST_WRITE;
                        end else begin
                            m00_axi_arvalid <= 1'b1;
                            state           <= ST_READ;
                        end
                    end
                end

                ST_WRITE: begin
                    if (aw_hs) begin
                        m00_axi_awvalid <= 1'b0;
                        aw_done         <= 1'b1;
                    end
                    if (w_hs) begin
                        m00_axi_wvalid <= 1'b0;
                        w_done         <= 1'b1;
                    end
                    // A handshake landing this cycle counts as done already.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done        <= 1'b0;
                        w_done         <= 1'b0;
                        m00_axi_bready <= 1'b1;
                        state          <= ST_WAIT_B;
                    end
                end

                ST_WAIT_B: begin
                    if (m00_axi_bvalid) begin
                        m00_axi_bready <= 1'b0;
                        resp_code_o    <= m00_axi_bresp;
                        resp_data_o    <= '0;
                        resp_we_o      <= we_q;
                        resp_v_o       <= 1'b1;
                        state          <= ST_RESP;
                    end
                end

                ST_READ: begin
                    if (m00_axi_arready) begin
                        m00_axi_arvalid <= 1'b0;
                        m00_axi_rready  <= 1'b1;
                        state           <= ST_WAIT_R;
                    end
                end

                ST_WAIT_R: begin
                    if (m00_axi_rvalid) begin
                        m00_axi_rready <= 1'b0;
                        resp_code_o    <= m00_axi_rresp;
                        resp_data_o    <= m00_axi_rdata;
                        resp_we_o      <= we_q;
                        resp_v_o       <= 1'b1;
                        state          <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (resp_ready_i) begin
                        resp_v_o    <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_master_bridge.sv
// Directed bench for axil_master_bridge against a small behavioural AXI-Lite slave
// with per-channel ready stalls, a held B channel and forced error responses.
module tb_axil_master_bridge;

    localparam int DW = 32;
    localparam int AW = 10;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    logic          cmd_v, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [3:0]    cmd_wstrb;
    logic          resp_v, resp_ready, resp_we;
    logic [DW-1:0] resp_data;
    logic [1:0]    resp_code;

    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot, dbg_state;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;

    axil_master_bridge #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_wstrb_i(cmd_wstrb),
        .resp_v_o(resp_v), .resp_ready_i(resp_ready), .resp_we_o(resp_we),
        .resp_data_o(resp_data), .resp_code_o(resp_code),
        .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
        .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
        .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
        .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
        .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
        .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
        .m00_axi_rready(rready), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    int          aw_stall = 0, w_stall = 0, ar_stall = 0;
    int          aw_wait, w_wait, ar_wait;
    logic        b_hold = 1'b0, force_r = 1'b0;
    logic [1:0]  force_bresp = 2'b00, force_rresp = 2'b00;
    logic [31:0] force_rdata = 32'h0;
    logic        aw_got, w_got, b_pend;
    logic [AW-1:0] aw_addr_s;
    logic [31:0] w_data_s;
    logic [3:0]  w_strb_s;
    logic [31:0] mem [0:255];
    int          aw_hs_cnt = 0, w_hs_cnt = 0;

    logic          aw_fire, w_fire, wr_now;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;

    assign awready = awvalid && (aw_wait >= aw_stall);
    assign wready  = wvalid && (w_wait >= w_stall);
    assign arready = arvalid && (ar_wait >= ar_stall);
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign wr_now  = (aw_got || aw_fire) && (w_got || w_fire);
    assign wr_addr = aw_fire ? awaddr : aw_addr_s;
    assign wr_data = w_fire ? wdata : w_data_s;
    assign wr_strb = w_fire ? wstrb : w_strb_s;

    always @(posedge aclk) begin
        if (areset) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
            aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            if (aw_fire) begin
                aw_got <= 1'b1; aw_addr_s <= awaddr; aw_hs_cnt <= aw_hs_cnt + 1;
            end
            if (w_fire) begin
                w_got <= 1'b1; w_data_s <= wdata; w_strb_s <= wstrb; w_hs_cnt <= w_hs_cnt + 1;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (wr_now) begin
                for (int i = 0; i < 4; i++)
                    if (wr_strb[i]) mem[wr_addr[9:2]][8*i +: 8] <= wr_data[8*i +: 8];
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                if (b_hold) b_pend <= 1'b1;
                else begin bvalid <= 1'b1; bresp <= force_bresp; end
            end
            if (b_pend && !b_hold) begin
                b_pend <= 1'b0; bvalid <= 1'b1; bresp <= force_bresp;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= force_r ? force_rdata : mem[araddr[9:2]];
                rresp  <= force_r ? force_rresp : 2'b00;
            end
        end
    end

    // ---------------- stability monitor (negedge sampled) ----------------
    logic          p_rst = 1'b1, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
    logic          p_arv = 1'b0, p_arr = 1'b0;
    logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
    logic [31:0]   p_wdata = '0;
    logic [3:0]    p_wstrb = '0;

    always @(negedge aclk) begin
        if (!areset && !p_rst) begin
            if (p_awv && !p_awr) check("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (p_wv && !p_wr)   check("w_hold", {wvalid, wstrb, wdata}, {1'b1, p_wstrb, p_wdata});
            if (p_arv && !p_arr) check("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
        end
        p_rst <= areset;
        p_awv <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
        p_wv  <= wvalid;  p_wr  <= wready;  p_wdata  <= wdata; p_wstrb <= wstrb;
        p_arv <= arvalid; p_arr <= arready; p_araddr <= araddr;
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n = 0;
        cmd_v = 1'b1; cmd_we = we; cmd_addr = a; cmd_data = d; cmd_wstrb = s;
        while (!cmd_ready && n < 40) begin @(negedge aclk); n++; end
        if (!cmd_ready) check("cmd_accept_timeout", cmd_ready, 1);
        @(negedge aclk);
        cmd_v = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input logic exp_we, input logic [31:0] exp_data,
                             input logic [1:0] exp_code);
        int n = 0;
        while (!resp_v && n < 60) begin @(negedge aclk); n++; end
        check({tag, "_resp_v"}, resp_v, 1);
        check({tag, "_code"}, resp_code, exp_code);
        check({tag, "_we"}, resp_we, exp_we);
        check({tag, "_data"}, resp_data, exp_data);
        @(negedge aclk);
    endtask

    task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] exp_code);
        send_cmd(1'b1, a, d, s);
        wait_resp(tag, 1'b1, 32'h0, exp_code);
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [31:0] exp_data,
                           input logic [1:0] exp_code);
        send_cmd(1'b0, a, 32'h0, 4'h0);
        wait_resp(tag, 1'b0, exp_data, exp_code);
    endtask

    int aw0, w0;
    int st_aw[3] = '{0, 2, 0};
    int st_w[3]  = '{2, 0, 0};

    initial begin
        areset = 1'b1; cmd_v = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0;
        cmd_wstrb = '0; resp_ready = 1'b1;
        repeat (3) @(negedge aclk);
        areset = 1'b0;

        // Reset state
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_valids", {awvalid, wvalid, arvalid, bready, rready, resp_v}, 6'b0);
        check("rst_resp", {resp_we, resp_code, resp_data}, 35'h0);
        check("rst_addr_data", {awaddr, araddr, wdata, wstrb}, 56'h0);
        check("rst_prot", {awprot, arprot}, 6'b0);
        check("rst_state", dbg_state, 3'd0);

        // 1: exact-latency write then read-back
        @(negedge aclk);
        cmd_v = 1'b1; cmd_we = 1'b1; cmd_addr = 10'h010; cmd_data = 32'hDEADBEEF; cmd_wstrb = 4'hF;
        check("t1_ready_T", cmd_ready, 1);
        @(negedge aclk); cmd_v = 1'b0;
        check("t1_aw_w_T1", {awvalid, wvalid, cmd_ready}, 3'b110);
        check("t1_payload", {awaddr, wdata, wstrb}, {10'h010, 32'hDEADBEEF, 4'hF});
        @(negedge aclk);
        check("t1_T2", {bready, awvalid, wvalid, resp_v}, 4'b1000);
        @(negedge aclk);
        check("t1_T3", {resp_v, resp_we, resp_code, bready}, 5'b11000);
        check("t1_T3_data", resp_data, 32'h0);
        @(negedge aclk);
        check("t1_done", {resp_v, cmd_ready}, 2'b01);
        cmd_v = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h010;
        @(negedge aclk); cmd_v = 1'b0;
        check("t1r_T1", {arvalid, araddr, awvalid}, {1'b1, 10'h010, 1'b0});
        @(negedge aclk);
        check("t1r_T2", {rready, arvalid, resp_v}, 3'b100);
        @(negedge aclk);
        check("t1r_T3", {resp_v, resp_we, resp_code}, 4'b1000);
        check("t1r_data", resp_data, 32'hDEADBEEF);
        @(negedge aclk);

        // 2: AW stalled 3 cycles, W immediate
        aw_stall = 3;
        send_cmd(1'b1, 10'h020, 32'hA5A50001, 4'hF);
        check("t2_T1", {awvalid, wvalid}, 2'b11);
        @(negedge aclk);
        check("t2_T2", {wvalid, awvalid, awaddr, bready}, {1'b0, 1'b1, 10'h020, 1'b0});
        @(negedge aclk);
        check("t2_T3", {awvalid, bready}, 2'b10);
        @(negedge aclk);
        check("t2_T4", {awvalid, bready}, 2'b10);
        @(negedge aclk);
        check("t2_T5", {awvalid, bready}, 2'b01);
        wait_resp("t2", 1'b1, 32'h0, 2'b00);
        aw_stall = 0;

        // 3: W stalled, AW stalled, both together
        for (int i = 0; i < 3; i++) begin
            aw_stall = st_aw[i]; w_stall = st_w[i];
            aw0 = aw_hs_cnt; w0 = w_hs_cnt;
            do_write("t3_wr", 10'h100 + 10'(i * 4), 32'hC0DE0000 + i, 4'hF, 2'b00);
            repeat (2) @(negedge aclk);
            check("t3_aw_beats", aw_hs_cnt - aw0, 1);
            check("t3_w_beats", w_hs_cnt - w0, 1);
        end
        aw_stall = 0; w_stall = 0;
        do_read("t3_rd", 10'h104, 32'hC0DE0001, 2'b00);

        // 4: error responses pass through
        force_r = 1'b1; force_rresp = 2'b10; force_rdata = 32'h12345678;
        do_read("t4_slverr", 10'h030, 32'h12345678, 2'b10);
        check("t4_idle", {cmd_ready, resp_v, dbg_state}, {1'b1, 1'b0, 3'd0});
        force_r = 1'b0;
        force_bresp = 2'b11;
        do_write("t4_decerr", 10'h034, 32'h1, 4'hF, 2'b11);
        force_bresp = 2'b00;

        // 5: response back-pressure
        resp_ready = 1'b0;
        send_cmd(1'b0, 10'h010, 32'h0, 4'h0);
        for (int n = 0; n < 10 && !resp_v; n++) @(negedge aclk);
        cmd_v = 1'b1; cmd_we = 1'b1; cmd_addr = 10'h060; cmd_data = 32'h600DF00D; cmd_wstrb = 4'hF;
        aw0 = aw_hs_cnt;
        for (int i = 0; i < 5; i++) begin
            check("t5_hold", {resp_v, resp_code, cmd_ready}, 4'b1000);
            check("t5_hold_data", resp_data, 32'hDEADBEEF);
            @(negedge aclk);
        end
        resp_ready = 1'b1;
        check("t5_release", {resp_v, cmd_ready}, 2'b10);
        @(negedge aclk);
        check("t5_after", {resp_v, cmd_ready, awvalid}, 3'b010);
        @(negedge aclk);
        cmd_v = 1'b0;
        check("t5_accepted", {awvalid, cmd_ready, awaddr}, {1'b1, 1'b0, 10'h060});
        wait_resp("t5_wr", 1'b1, 32'h0, 2'b00);
        check("t5_aw_beats", aw_hs_cnt - aw0, 1);

        // 6: reset while waiting for B
        b_hold = 1'b1;
        send_cmd(1'b1, 10'h070, 32'hFFFFFFFF, 4'hF);
        @(negedge aclk);
        check("t6_wait_b", {bready, bvalid}, 2'b10);
        areset = 1'b1;
        @(negedge aclk);
        check("t6_rst_valids", {awvalid, wvalid, arvalid, bready, rready, resp_v}, 6'b0);
        check("t6_rst_idle", {cmd_ready, dbg_state}, {1'b1, 3'd0});
        areset = 1'b0; b_hold = 1'b0;
        @(negedge aclk);
        do_write("t6_wr", 10'h050, 32'h55AA55AA, 4'h3, 2'b00);
        do_read("t6_rd", 10'h050, 32'h000055AA, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        check("global_timeout", 1'b1, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "FAIL global_timeout reached");
    end

endmodule

// File: doc/axil_master_bridge.md
Name: axil_master_bridge

Overview:
- AXI4-Lite initiator: turns a simple valid/ready command stream (read or write) into one AXI4-Lite transaction on the m00_axi bus, then returns read data and the response code on a valid/ready response stream.
- PL-side counterpart of our AXI4-Lite register slave. Lets fabric logic drive AXI-Lite slaves, and lets the cosim bench drive top_zynq's s00_axi port from a command trace.
- At most one transaction outstanding.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, AXI-Lite data width (32 or 64).
- C_M_AXI_ADDR_WIDTH, 10, AXI-Lite address width.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- cmd_v_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when cmd_v_i & cmd_ready_o
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  C_M_AXI_ADDR_WIDTH  byte address
- cmd_data_i  in  C_M_AXI_DATA_WIDTH  write data
- cmd_wstrb_i  in  C_M_AXI_DATA_WIDTH/8  write strobes
- resp_v_o  out  1  response valid
- resp_ready_i  in  1  response consumed when resp_v_o & resp_ready_i
- resp_we_o  out  1  echo of the command type
- resp_data_o  out  C_M_AXI_DATA_WIDTH  read data (0 for writes)
- resp_code_o  out  2  BRESP or RRESP
- m00_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master directions and widths. awprot and arprot are tied to 3'b000.

Behaviour:
- FSM states: IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP.
- Reset: state IDLE. cmd_ready_o=1. All valid/ready outputs=0. resp_data_o, resp_code_o, resp_we_o = 0. Address and data registers = 0.
- IDLE:
  - cmd_ready_o=1; it is 0 in every other state.
  - On a command handshake, register addr, data, wstrb and we.
  - Go to WRITE if we=1, else READ.
- WRITE:
  - awvalid and wvalid both assert in the cycle after acceptance.
  - Flags aw_done and w_done each set on their own handshake; each channel deasserts its valid independently.
  - Handshakes may occur in either order or in the same cycle.
  - When both are done (counting a handshake in the current cycle), clear the flags and go to WAIT_B.
  - awaddr, wdata and wstrb stay stable while their valid is high.
- WAIT_B:
  - bready=1.
  - On bvalid, latch bresp into resp_code_o, set resp_data_o=0 and resp_we_o=1, go to RESP.
  - bready is 0 in every other state.
- READ:
  - arvalid=1 until arready, then go to WAIT_R.
- WAIT_R:
  - rready=1.
  - On rvalid, latch rdata and rresp, set resp_we_o=0, go to RESP.
- RESP:
  - resp_v_o=1; outputs held stable until resp_ready_i.
  - Then go to IDLE; the next command can be accepted the cycle after.
- Latency with a zero-wait slave:
  - Write: accept at T, AW/W handshake at T+1, B at T+2, resp_v_o at T+3.
  - Read: accept at T, AR at T+1, R at T+2, resp_v_o at T+3.
- Valids never drop before their handshake (AXI rule). No combinational path from any AXI input to any AXI output valid or ready.
- SLVERR and DECERR pass through unchanged in resp_code_o; they do not stall or alter the FSM.
- areset mid-transaction:
  - Return to IDLE and drop all valids and readies next cycle.
  - Caller must reset the slave concurrently; the bridge does not drain outstanding AXI transactions.
- cmd_v_i outside IDLE is ignored; cmd_ready_o=0 there.

Decomposition:
- Package axil_pkg:
  - AXI resp codes: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - FSM state enum.
  - Parameterized packed structs for command and response, shared with the existing slave-side cosim code.
- No sub-module: a single FSM plus registers.

Test Plan:
1. Write addr=0x010, data=0xDEADBEEF, wstrb=4'hF to the example register slave; zero-wait slave and resp_ready_i=1. Expect awvalid and wvalid at T+1, resp_v_o at T+3 with resp_code_o=2'b00, resp_we_o=1; a follow-up read of 0x010 returns resp_data_o=0xDEADBEEF, resp_code_o=2'b00.
2. Slave stalls awready 3 cycles while wready is immediate. Expect wvalid to drop after its own handshake, awvalid and awaddr held until awready, bready high only in WAIT_B; response OKAY.
3. wready stalls 2 cycles while awready is immediate, then the reverse order, then both handshakes in the same cycle. Expect exactly one AW and one W handshake per command and no duplicate beats in all three cases.
4. Slave returns rresp=2'b10 with rdata=0x12345678. Expect resp_code_o=2'b10 and resp_data_o=0x12345678; the FSM returns to IDLE.
5. resp_ready_i held 0 for 5 cycles. Expect resp_v_o and its data stable throughout and cmd_ready_o=0; a new cmd_v_i is not accepted until the cycle after resp_ready_i=1.
6. Assert areset while in WAIT_B. Expect the next cycle to show all AXI valids and readies at 0, cmd_ready_o=1, resp_v_o=0; a write issued after reset completes with OKAY.
